fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for the distributed-RAM async FIFO. It runs in the FIFO read clock domain and consumes the FIFO's empty/rd_en/dout interface (one-cycle registered read latency). It re-presents the data as a valid/ready stream with full one-word-per-cycle throughput, using a two-entry output buffer that absorbs the in-flight read. Downstream consumers attach here instead of driving i_rd_en directly, so no consumer has to track FIFO read latency.

## Interface
- FIFO_WIDTH, 8, data width; must equal the FIFO's FIFO_WIDTH
- CNT_WIDTH, 16, width of the delivered-word counter
- clk  in  1  read clock, same clock as the FIFO read side
- reset_async_n  in  1  asynchronous, active-low reset
- i_fifo_empty  in  1  FIFO empty flag
- o_fifo_rd_en  out  1  FIFO read enable
- iv_fifo_dout  in  FIFO_WIDTH  FIFO read data, valid the cycle after o_fifo_rd_en
- o_valid  out  1  stream data valid
- ov_data  out  FIFO_WIDTH  stream data
- i_ready  in  1  downstream accepts ov_data when o_valid & i_ready
- i_flush  in  1  synchronous discard of buffered and in-flight words
- ov_level  out  2  words held in the output buffer (0..2)
- ov_word_cnt  out  CNT_WIDTH  count of words delivered (handshakes)

## Operation
- **Reset values.** All state resets: o_valid=0, ov_data=0, ov_level=0, ov_word_cnt=0, inflight=0.
- **Read gate.** A gate register resets to 0 and becomes 1 on the first clock edge after reset release. o_fifo_rd_en is forced to 0 while the gate is 0.
- **Buffer states.** The output buffer is a head register (drives ov_data) plus a skid register.
  - EMPTY (level 0)
  - ONE (head valid)
  - TWO (head and skid valid)
  - o_valid = (state != EMPTY).
- **Signals.**
  - pop = o_valid & i_ready.
  - inflight = registered o_fifo_rd_en.
  - arrive = inflight & ~i_flush_d, where i_flush_d is i_flush registered.
- **Read issue (combinational).** o_fifo_rd_en = gate & ~i_fifo_empty & ~i_flush & (level + inflight - pop <= 1). This keeps level + inflight ≤ 2 at all times, so the buffer never overflows.
- **Transitions** (per clock, i_flush low):
  - EMPTY: arrive → ONE, head = iv_fifo_dout.
  - ONE: arrive & ~pop → TWO, skid = dout. arrive & pop → ONE, head = dout. ~arrive & pop → EMPTY. Otherwise hold.
  - TWO: pop → ONE, head = skid. arrive cannot occur in TWO without pop; if it occurs, the result is TWO with head = skid and skid = dout.
- **Data ordering.** Data leaves in FIFO order. No word is duplicated or dropped except by flush.
- **Flush.** In any cycle with i_flush=1:
  - o_fifo_rd_en = 0.
  - Next state is EMPTY and o_valid is 0 from the next cycle.
  - A word arriving in the cycle after flush (read issued before flush) is discarded.
  - A pop coinciding with the flush cycle still counts as delivered.
- **Counter.** ov_word_cnt increments on every pop and wraps modulo 2^CNT_WIDTH. Flush does not clear it.
- **Mid-operation reset.** Assertion of reset_async_n low clears all state immediately. Words already read from the FIFO are lost; the FIFO's own reset is the owner's responsibility.

## Timing
- **Fill latency.** i_fifo_empty falls (sampled in cycle N) → o_fifo_rd_en=1 in cycle N → dout valid in N+1 → o_valid=1 in N+2.
- **Throughput.** One word per cycle with i_ready held high and FIFO non-empty. Steady state is level=1 with inflight=1.
- **Backpressure.** After i_ready drops:
  - at most one further read is issued;
  - level reaches 2 and o_fifo_rd_en stays 0 until a pop.
- **Hold stability.** ov_data and o_valid are registered and stay stable while o_valid & ~i_ready.
- **Flush latency.** i_flush is honored in the same cycle for rd_en and on the next edge for buffer state.

## Test plan
- **Reset.** Release reset with FIFO non-empty → o_fifo_rd_en=0 in the first cycle after release, then 1; o_valid rises 2 cycles after the first rd_en; all outputs are 0 during reset.
- **Streaming.** FIFO preloaded with 0x01..0x10, i_ready=1 → 16 consecutive cycles of o_valid with data 0x01..0x10 and no gap; ov_word_cnt=16; o_fifo_rd_en pulses exactly 16 times.
- **Backpressure.** i_ready toggles 1,0,0,1 repeatedly on 32 words → output sequence intact, ov_level never exceeds 2, exactly 32 rd_en pulses in total.
- **Flush.** Assert i_flush for 1 cycle while level=1 and inflight=1 → o_valid=0 next cycle, the in-flight word is not delivered, and the next delivered word is the FIFO's following entry.
- **Empty boundary.** FIFO holds 1 word, i_ready=0 → level=1, rd_en stays 0 while empty; then write 2 words → level reaches 2, one rd_en outstanding is blocked until the next pop.
- **Counter wrap.** CNT_WIDTH=4, deliver 17 words → ov_word_cnt=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side drain engine for the distributed-RAM async FIFO. It pulls words
// from the FIFO read port (one-cycle registered read latency) and presents
// them as a valid/ready stream at up to one word per clock. A two-entry
// output buffer (head + skid) absorbs the word still in flight when
// downstream stalls.
//
// Ports:
//   clk            read-domain clock (same as the FIFO read side)
//   reset_async_n  asynchronous active-low reset
//   i_fifo_empty   FIFO empty flag
//   o_fifo_rd_en   FIFO read enable
//   iv_fifo_dout   FIFO read data, valid the cycle after o_fifo_rd_en
//   o_valid        stream data valid
//   ov_data        stream data (head register)
//   i_ready        downstream accept; transfer on o_valid & i_ready
//   i_flush        synchronous discard of buffered and in-flight words
//   ov_level       words held in the output buffer (0..2)
//   ov_word_cnt    delivered-word count, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_async_n,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] iv_fifo_dout,
  output logic                  o_valid,
  output logic [FIFO_WIDTH-1:0] ov_data,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic [1:0]            ov_level,
  output logic [CNT_WIDTH-1:0]  ov_word_cnt
);

  // Encoding doubles as the buffer fill level.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [FIFO_WIDTH-1:0] head, head_nxt;
  logic [FIFO_WIDTH-1:0] skid, skid_nxt;
  logic                  gate;
  logic                  inflight;
  logic                  flush_d;
  logic                  pop;
  logic                  arrive;
  logic [2:0]            occupancy;

  always_comb begin
    o_valid  = (state != EMPTY);
    ov_data  = head;
    ov_level = state;
    pop      = o_valid & i_ready;
    arrive   = inflight & ~flush_d;
  end

  // Issue a read only if the word still fits once everything already
  // committed (buffered + in flight, less this cycle's pop) has landed.
  // Written as level + inflight <= 1 + pop to avoid an unsigned underflow.
  always_comb begin
    occupancy    = {1'b0, ov_level} + {2'b00, inflight};
    o_fifo_rd_en = gate & ~i_fifo_empty & ~i_flush &
                   (occupancy <= (3'd1 + {2'b00, pop}));
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (i_flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (arrive) begin
            state_nxt = ONE;
            head_nxt  = iv_fifo_dout;
          end
        end
        ONE: begin
          if (arrive && !pop) begin
            state_nxt = TWO;
            skid_nxt  = iv_fifo_dout;
          end else if (arrive && pop) begin
            head_nxt  = iv_fifo_dout;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // The read gate keeps arrive out of TWO; if it ever happens the
          // buffer shifts and stays full.
          if (arrive) begin
            head_nxt = skid;
            skid_nxt = iv_fifo_dout;
          end else if (pop) begin
            state_nxt = ONE;
            head_nxt  = skid;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state       <= EMPTY;
      head        <= '0;
      skid        <= '0;
      gate        <= 1'b0;
      inflight    <= 1'b0;
      flush_d     <= 1'b0;
      ov_word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      head     <= head_nxt;
      skid     <= skid_nxt;
      gate     <= 1'b1;
      inflight <= o_fifo_rd_en;
      flush_d  <= i_flush;
      if (pop) begin
        ov_word_cnt <= ov_word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset_async_n;
  logic         fifo_empty = 1'b1;
  logic         rd_en;
  logic [W-1:0] fifo_dout = '0;
  logic         o_valid;
  logic [W-1:0] ov_data;
  logic         i_ready;
  logic         i_flush;
  logic [1:0]   ov_level;
  logic [CW-1:0] ov_word_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset_async_n(reset_async_n),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (rd_en),
    .iv_fifo_dout (fifo_dout),
    .o_valid      (o_valid),
    .ov_data      (ov_data),
    .i_ready      (i_ready),
    .i_flush      (i_flush),
    .ov_level     (ov_level),
    .ov_word_cnt  (ov_word_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Behavioural FIFO: registered read data, registered empty flag.
  logic [W-1:0] mem_q[$];
  logic [W-1:0] pend_q[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (rd_en && mem_q.size() > 0) fifo_dout <= mem_q.pop_front();
    while (pend_q.size() > 0) mem_q.push_back(pend_q.pop_front());
    fifo_empty <= (mem_q.size() == 0);
  end

  task automatic write_word(input logic [W-1:0] v);
    pend_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // Scoreboard monitor. Every word read from the FIFO is either delivered
  // in order or, on flush, lost together with everything else read but
  // not yet delivered.
  int   reads = 0;
  int   retired = 0;
  int   discarded = 0;
  int   exp_cnt = 0;
  logic prev_hold = 1'b0;
  logic prev_rd = 1'b0;
  logic flush_seen = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset_async_n) begin
      if (flush_seen) chk("flush_valid_next", o_valid, 0);
      flush_seen = 1'b0;
      if (prev_hold) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", ov_data, prev_data);
      end
      chk("word_cnt", ov_word_cnt, exp_cnt % (1 << CW));
      chk("level_vs_valid", ov_level != 0, o_valid);
      chk("level_plus_inflight", (ov_level + prev_rd) <= 2, 1);
      if (rd_en) begin
        chk("rd_en_while_empty", fifo_empty, 0);
        reads++;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else chk("stream_data", ov_data, exp_q.pop_front());
        retired++;
        exp_cnt++;
      end
      if (i_flush) begin
        while (retired < reads) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          retired++;
          discarded++;
        end
        flush_seen = 1'b1;
      end
      prev_hold = o_valid && !i_ready && !i_flush;
      prev_data = ov_data;
      prev_rd   = rd_en;
    end
  end

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode, input int budget, input string name);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      if (mode == 1) i_ready = (c % 4 == 0) || (c % 4 == 3);
      else           i_ready = 1'b1;
      @(negedge clk);
      if (exp_q.size() == 0 && !o_valid && fifo_empty && pend_q.size() == 0 && !rd_en)
        done = 1;
    end
    if (!done) fail_now(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int base;
    int d0;
    bit found;
    reset_async_n = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;

    // Reset: FIFO preloaded with 0x01..0x10 while held in reset.
    for (int i = 1; i <= 16; i++) write_word(W'(i));
    repeat (3) @(negedge clk);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_data", ov_data, 0);
    chk("reset_level", ov_level, 0);
    chk("reset_cnt", ov_word_cnt, 0);
    chk("reset_fifo_loaded", fifo_empty, 0);

    @(posedge clk);
    #1;
    reset_async_n = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    chk("gate_first_cycle_rd_en", rd_en, 0);
    @(negedge clk);
    chk("gate_open_rd_en", rd_en, 1);
    @(negedge clk);
    chk("fill_valid_n1", o_valid, 0);
    @(negedge clk);
    chk("fill_valid_n2", o_valid, 1);

    // Streaming: 16 back-to-back words.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("stream_no_gap", o_valid, 1);
    end
    @(negedge clk);
    chk("stream_end_valid", o_valid, 0);
    chk("stream_rd_pulses", reads, 16);
    chk("stream_cnt_wrapped", ov_word_cnt, 0);

    // Backpressure: ready 1,0,0,1 over 32 words.
    base = reads;
    for (int i = 0; i < 32; i++) write_word(W'($urandom));
    drain(1, 400, "bp_drain_timeout");
    chk("bp_rd_pulses", reads - base, 32);

    // Flush while head valid and a read is in flight.
    for (int i = 0; i < 8; i++) write_word(W'(8'hA0 + i));
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      i_ready = 1'b1;
      @(negedge clk);
      if (o_valid && rd_en && ov_level == 1) found = 1;
    end
    if (!found) fail_now("flush_steady_state");
    d0 = discarded;
    @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_low", o_valid, 0);
    chk("flush_one_dropped", discarded - d0, 1);
    drain(0, 100, "flush_drain_timeout");

    // Empty boundary: one word with ready low, then two more.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    write_word(8'h55);
    repeat (5) @(negedge clk);
    chk("empty_level1", ov_level, 1);
    chk("empty_rd_en_low", rd_en, 0);
    chk("empty_fifo_empty", fifo_empty, 1);
    write_word(8'h66);
    write_word(8'h77);
    repeat (5) @(negedge clk);
    chk("boundary_level2", ov_level, 2);
    chk("boundary_rd_blocked", rd_en, 0);
    chk("boundary_fifo_nonempty", fifo_empty, 0);
    drain(0, 100, "boundary_drain_timeout");

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      i_ready = ($urandom_range(0, 9) < 7);
      i_flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) write_word(W'($urandom));
    end
    drain(0, 1500, "random_drain_timeout");

    @(negedge clk);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_reads_accounted", reads, retired);
    chk("final_cnt", ov_word_cnt, exp_cnt % (1 << CW));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
